manchester_to_pam4: RTL and testbench
=====================================

Name: manchester_to_pam4

Overview:
- Receive-side counterpart of the PAM4 -> NRZ -> Manchester transmit chain.
- Recovers half-bit alignment from a serial Manchester stream and decodes each half-bit pair to one NRZ bit.
- Packs NRZ bits MSB-first into 2-bit PAM4 symbols, flagging code violations and lock status.
- Sits at the line-side input of the receiver, clocked at the half-bit rate: one Manchester half-bit per clk.

Parameters:
- LOCK_CNT, 4, consecutive valid half-bit pairs required in HUNT before locked asserts (min 1).
- ERR_W, 8, width of the saturating code-violation counter.

Ports:
- clk, input, 1, half-bit-rate clock; all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
- Manchester_in, input, 1, serial Manchester line; one half-bit sampled per clk.
- PAM4_out, output, 2, last decoded symbol; first-received bit is MSB.
- PAM4_valid, output, 1, one-cycle pulse when PAM4_out is updated.
- locked, output, 1, high while half-bit and symbol alignment are established.
- code_err, output, 1, one-cycle pulse on any invalid pair (00 or 11).
- err_count, output, ERR_W, saturating count of code_err events since reset.

Behaviour:
- One clock domain only. Reset is synchronous and active-high: on a clk edge with reset=1, clear all state and outputs.
- Reset values:
  - PAM4_out=2'b00, PAM4_valid=0, locked=0, code_err=0, err_count=0.
  - FSM=HUNT, half-phase=0, bit index=0, lock counter=0.
- Encoding, fixed for the team: NRZ 1 = half-bits 1 then 0; NRZ 0 = half-bits 0 then 1. Pairs 00 and 11 are code violations.
- Half-phase: phase 0 captures the first half. Phase 1 evaluates the pair {first, current} and returns to phase 0.
- FSM state HUNT:
  - Valid pair: lock counter +1. When it reaches LOCK_CNT, go to LOCKED, set locked=1 and bit index=0. The pair that completes lock is not assembled into a symbol.
  - Invalid pair: code_err=1, err_count+1, lock counter=0. Slip by one half-bit: the current half becomes the new first half and phase stays at 1 for the next cycle.
- FSM state LOCKED:
  - Valid pair at bit index 0: store the bit as MSB; index becomes 1.
  - Valid pair at bit index 1: PAM4_out = {MSB, bit}; PAM4_valid=1 for one cycle; index becomes 0.
  - Invalid pair: code_err=1, err_count+1, locked=0. Go to HUNT with the same slip rule and lock counter=0. Discard any partial symbol (index=0); PAM4_out keeps its old value; no PAM4_valid.
- Latency: PAM4_out and PAM4_valid register on the edge that samples the 4th half-bit of a symbol, so they are visible in the following cycle. A symbol therefore takes 4 clk once locked.
- code_err registers on the edge that samples the offending second half.
- PAM4_out holds between PAM4_valid pulses.
- err_count saturates at 2^ERR_W-1 and does not wrap; code_err still pulses when saturated.
- Ambiguity: a constant-bit stream is valid at either alignment. The transmitter sends an alternating preamble (1010...) of at least LOCK_CNT+1 bits, which forces a misaligned receiver to see violations and slip.
- Reset asserted mid-symbol or mid-hunt aborts immediately to reset values. No PAM4_valid is issued for the partial symbol.

Test Plan:
- Reset: hold reset 3 cycles with Manchester_in toggling -> all outputs at reset values, no code_err or PAM4_valid pulses.
- Aligned lock and decode (LOCK_CNT=4):
  - Stimulus: half-bits 10 01 10 01, then symbols 2'b10, 2'b11, 2'b00, 2'b01 (halves 10 01, 10 10, 01 01, 01 10).
  - Required: locked rises after the 4th pair; four PAM4_valid pulses 4 clk apart carrying 10, 11, 00, 01; code_err never asserts.
- Misaligned start: same stream prefixed by one extra 0 half-bit -> at least one code_err and slip, err_count>=1, then lock. First symbols after lock decode per the MSB rule; verify against the reference model.
- Violation while locked:
  - Stimulus: after lock, send MSB pair 10, then 11.
  - Required: code_err pulse, locked drops the next cycle, no PAM4_valid for the partial symbol, PAM4_out unchanged.
  - Then send LOCK_CNT valid pairs -> relock, and the next symbol decodes correctly.
- Saturation (ERR_W=2): feed a constant-1 line for 20 clk -> err_count reaches 3 and holds; code_err keeps pulsing.
- Reset mid-symbol: assert reset after the MSB pair while locked -> next cycle all outputs at reset values. A fresh preamble relocks normally.

Source files
------------

// File: rtl/manchester_to_pam4.sv
// manchester_to_pam4
//   Line-side Manchester receiver clocked at the half-bit rate. Recovers
//   half-bit pair alignment, decodes each pair to one NRZ bit (10 -> 1,
//   01 -> 0) and packs bits MSB-first into 2-bit PAM4 symbols.
//
// Ports:
//   clk           half-bit-rate clock, rising edge
//   reset         synchronous active-high reset
//   Manchester_in serial Manchester line, one half-bit per clk
//   PAM4_out      last decoded symbol, first-received bit is MSB
//   PAM4_valid    one-cycle pulse when PAM4_out updates
//   locked        high while pair and symbol alignment are established
//   code_err      one-cycle pulse on an invalid pair (00 or 11)
//   err_count     saturating count of code_err events since reset
module manchester_to_pam4 #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Manchester_in,
    output logic [1:0]       PAM4_out,
    output logic             PAM4_valid,
    output logic             locked,
    output logic             code_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned CntW = $clog2(LOCK_CNT + 1);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    state_e            state_q, state_d;
    logic              phase_q, phase_d;
    logic              first_q, first_d;
    logic              bit_idx_q, bit_idx_d;
    logic              msb_q, msb_d;
    logic [CntW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [1:0]        pam4_q, pam4_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;
    logic              code_err_q, code_err_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic pair_ok;
    assign pair_ok = first_q ^ Manchester_in;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        first_d    = first_q;
        bit_idx_d  = bit_idx_q;
        msb_d      = msb_q;
        lock_cnt_d = lock_cnt_q;
        pam4_d     = pam4_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        code_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;

        if (!phase_q) begin
            first_d = Manchester_in;
            phase_d = 1'b1;
        end else if (pair_ok) begin
            phase_d = 1'b0;
            unique case (state_q)
                StHunt: begin
                    // The pair completing lock is consumed, not assembled.
                    if (lock_cnt_q + CntW'(1) == CntW'(LOCK_CNT)) begin
                        state_d    = StLocked;
                        locked_d   = 1'b1;
                        bit_idx_d  = 1'b0;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + CntW'(1);
                    end
                end
                StLocked: begin
                    // Decoded bit equals the first half of the pair.
                    if (!bit_idx_q) begin
                        msb_d     = first_q;
                        bit_idx_d = 1'b1;
                    end else begin
                        pam4_d    = {msb_q, first_q};
                        valid_d   = 1'b1;
                        bit_idx_d = 1'b0;
                    end
                end
                default: state_d = StHunt;
            endcase
        end else begin
            // Violation: slip one half-bit so the current half starts the next pair.
            code_err_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            first_d    = Manchester_in;
            phase_d    = 1'b1;
            lock_cnt_d = '0;
            state_d    = StHunt;
            locked_d   = 1'b0;
            bit_idx_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StHunt;
            phase_q    <= 1'b0;
            first_q    <= 1'b0;
            bit_idx_q  <= 1'b0;
            msb_q      <= 1'b0;
            lock_cnt_q <= '0;
            pam4_q     <= 2'b00;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            code_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
            bit_idx_q  <= bit_idx_d;
            msb_q      <= msb_d;
            lock_cnt_q <= lock_cnt_d;
            pam4_q     <= pam4_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            code_err_q <= code_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign PAM4_out   = pam4_q;
    assign PAM4_valid = valid_q;
    assign locked     = locked_q;
    assign code_err   = code_err_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_manchester_to_pam4.sv
module tb_manchester_to_pam4;

    logic       clk = 1'b0;
    logic       reset;
    logic       man_in;
    logic [1:0] pam4_out;
    logic       pam4_valid;
    logic       locked;
    logic       code_err;
    logic [7:0] err_count;

    logic       sat_reset;
    logic       sat_in;
    logic [1:0] sat_pam4_out;
    logic       sat_pam4_valid;
    logic       sat_locked;
    logic       sat_code_err;
    logic [1:0] sat_err_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    manchester_to_pam4 #(.LOCK_CNT(4), .ERR_W(8)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .Manchester_in(man_in),
        .PAM4_out     (pam4_out),
        .PAM4_valid   (pam4_valid),
        .locked       (locked),
        .code_err     (code_err),
        .err_count    (err_count)
    );

    manchester_to_pam4 #(.LOCK_CNT(4), .ERR_W(2)) u_sat (
        .clk          (clk),
        .reset        (sat_reset),
        .Manchester_in(sat_in),
        .PAM4_out     (sat_pam4_out),
        .PAM4_valid   (sat_pam4_valid),
        .locked       (sat_locked),
        .code_err     (sat_code_err),
        .err_count    (sat_err_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one half-bit, then sample #1 after the edge that captured it.
    task automatic send(input logic h);
        man_in = h;
        @(posedge clk);
        #1;
    endtask

    // Send the four halves of one symbol (h[3] first) while locked.
    task automatic send_sym(input string tag, input logic [3:0] h, input logic [1:0] exp);
        send(h[3]);
        send(h[2]);
        send(h[1]);
        chk({tag, "_novalid"}, 16'(pam4_valid), 16'd0);
        send(h[0]);
        chk({tag, "_valid"}, 16'(pam4_valid), 16'd1);
        chk({tag, "_out"}, 16'(pam4_out), 16'(exp));
        chk({tag, "_noerr"}, 16'(code_err), 16'd0);
    endtask

    task automatic send_halves(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send(v[i]);
    endtask

    initial begin
        reset     = 1'b1;
        man_in    = 1'b0;
        sat_reset = 1'b1;
        sat_in    = 1'b0;

        // Reset held 3 cycles with a toggling line.
        for (int i = 0; i < 3; i++) begin
            send(i[0]);
            chk("rst_valid", 16'(pam4_valid), 16'd0);
            chk("rst_err", 16'(code_err), 16'd0);
        end
        chk("rst_out", 16'(pam4_out), 16'd0);
        chk("rst_locked", 16'(locked), 16'd0);
        chk("rst_cnt", 16'(err_count), 16'd0);
        reset = 1'b0;

        // Aligned preamble 10 01 10 01.
        send_halves(16'b100110, 6);
        chk("pre_unlocked", 16'(locked), 16'd0);
        send_halves(16'b01, 2);
        chk("pre_locked", 16'(locked), 16'd1);
        chk("pre_noerr", 16'(code_err), 16'd0);
        send_sym("sym10", 4'b1001, 2'b10);
        send_sym("sym11", 4'b1010, 2'b11);
        send_sym("sym00", 4'b0101, 2'b00);
        send_sym("sym01", 4'b0110, 2'b01);
        chk("al_cnt", 16'(err_count), 16'd0);

        // Violation while locked: MSB pair 10 then 11.
        send_halves(16'b10, 2);
        chk("vl_msb_novalid", 16'(pam4_valid), 16'd0);
        send_halves(16'b11, 2);
        chk("vl_err", 16'(code_err), 16'd1);
        chk("vl_unlock", 16'(locked), 16'd0);
        chk("vl_novalid", 16'(pam4_valid), 16'd0);
        chk("vl_hold", 16'(pam4_out), 16'd1);
        chk("vl_cnt", 16'(err_count), 16'd1);
        // Slipped '1' pairs with next 0, then 10 01 10 -> 4 valid pairs.
        send_halves(16'b0100110, 7);
        chk("vl_relock", 16'(locked), 16'd1);
        chk("vl_relock_noerr", 16'(code_err), 16'd0);
        send_sym("vl_sym11", 4'b1010, 2'b11);

        // Reset mid-symbol after the MSB pair.
        send_halves(16'b01, 2);
        reset = 1'b1;
        send(1'b1);
        chk("mr_out", 16'(pam4_out), 16'd0);
        chk("mr_valid", 16'(pam4_valid), 16'd0);
        chk("mr_locked", 16'(locked), 16'd0);
        chk("mr_err", 16'(code_err), 16'd0);
        chk("mr_cnt", 16'(err_count), 16'd0);
        reset = 1'b0;
        send_halves(16'b10011001, 8);
        chk("mr_relock", 16'(locked), 16'd1);
        send_sym("mr_sym01", 4'b0110, 2'b01);

        // Misaligned start: extra 0 before the preamble.
        reset = 1'b1;
        send(1'b0);
        reset = 1'b0;
        send_halves(16'b0100, 4);
        chk("ma_err", 16'(code_err), 16'd1);
        chk("ma_cnt", 16'(err_count), 16'd1);
        // Lock completes on the first symbol's MSB pair, which is consumed.
        send_halves(16'b1100110, 7);
        chk("ma_locked", 16'(locked), 16'd1);
        send_sym("ma_sym01", 4'b0110, 2'b01);
        send_sym("ma_sym10", 4'b1001, 2'b10);
        send_sym("ma_sym00", 4'b0101, 2'b00);
        chk("ma_cnt_end", 16'(err_count), 16'd1);

        // Saturation on the ERR_W=2 instance: constant-1 line for 20 clk.
        sat_reset = 1'b0;
        sat_in    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk("sat_pulse", 16'(sat_code_err), (k == 1) ? 16'd0 : 16'd1);
            chk("sat_cnt", 16'(sat_err_count), 16'((k - 1 > 3) ? 3 : k - 1));
        end
        chk("sat_unlocked", 16'(sat_locked), 16'd0);
        chk("sat_novalid", 16'(sat_pam4_valid), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
